// File: rtl/iod_clk_train_ctrl.sv
// HS_IO_CLK training sequencer: sweeps the PLL phase, scores IOD eye-monitor flags per step
// and re-centres on the longest clean run. Optional STEP_MAP output: IOD_CLK_TRAIN_STEP_MAP_EN.
module iod_clk_train_ctrl #(
  parameter int MAX_STEPS     = 16,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_CYCLES = 32
) (
  input  logic                 FAB_CLK,
  input  logic                 RX_SYNC_RST,
  input  logic                 TRAIN_START,
  input  logic                 PLL_LOCK,
  input  logic [2:0]           LANE_WIDTH_CFG,
  input  logic                 EYE_MONITOR_EARLY_0,
  input  logic                 EYE_MONITOR_LATE_0,
  output logic                 EYE_MONITOR_CLEAR_FLAGS_0,
  output logic [2:0]           EYE_MONITOR_LANE_WIDTH,
  output logic                 PHASE_MOVE,
  output logic                 PHASE_DIR,
  output logic                 BUSY,
  output logic                 TRAIN_DONE,
  output logic                 TRAIN_FAIL,
  output logic [6:0]           BEST_STEP
`ifdef IOD_CLK_TRAIN_STEP_MAP_EN
  ,
  output logic [MAX_STEPS-1:0] STEP_MAP
`endif
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SMP_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int CNT_W = (SET_W > SMP_W) ? SET_W : SMP_W;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [6:0]       LAST_POS    = 7'(MAX_STEPS - 1);

  typedef enum logic [3:0] {
    IDLE, CLEAR, SETTLE, SAMPLE, EVAL, STEP, CENTER, CSETTLE, DONE, FAIL
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dirty;
  logic [6:0]       pos, run_len, run_start, best_len, best_start, target;

  logic       last_step;
  logic [6:0] run_len_n, run_start_n, close_len, close_start;
  logic [6:0] best_len_n, best_start_n, target_n;

  // Run bookkeeping for the step being evaluated; a clean last step closes its run too.
  // NOTE: every variable gets a default at the top of the block so no latch is inferred.
  always_comb begin
    last_step    = (pos == LAST_POS);
    run_len_n    = 7'd0;
    run_start_n  = run_start;
    close_len    = run_len;
    close_start  = run_start;
    if (!dirty) begin
      run_len_n   = run_len + 7'd1;
      run_start_n = (run_len == 7'd0) ? pos : run_start;
      close_len   = last_step ? run_len_n : 7'd0;
      close_start = run_start_n;
    end
    best_len_n   = best_len;
    best_start_n = best_start;
    if (close_len > best_len) begin
      best_len_n   = close_len;
      best_start_n = close_start;
    end
    target_n = best_start_n + (best_len_n >> 1);
  end

  // NOTE: state and outputs use non-blocking assignments; the synchronous reset clears every register.
  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      state                     <= IDLE;
      cnt                       <= '0;
      dirty                     <= 1'b0;
      pos                       <= 7'd0;
      run_len                   <= 7'd0;
      run_start                 <= 7'd0;
      best_len                  <= 7'd0;
      best_start                <= 7'd0;
      target                    <= 7'd0;
      EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b0;
      EYE_MONITOR_LANE_WIDTH    <= 3'b000;
      PHASE_MOVE                <= 1'b0;
      PHASE_DIR                 <= 1'b0;
      BUSY                      <= 1'b0;
      TRAIN_DONE                <= 1'b0;
      TRAIN_FAIL                <= 1'b0;
      BEST_STEP                 <= 7'd0;
`ifdef IOD_CLK_TRAIN_STEP_MAP_EN
      STEP_MAP                  <= '0;
`endif
    end else begin
      EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b0;
      PHASE_MOVE                <= 1'b0;
      if (BUSY && !PLL_LOCK) begin
        // Lock loss wins over any pending move or completion.
        state      <= FAIL;
        BUSY       <= 1'b0;
        TRAIN_FAIL <= 1'b1;
        BEST_STEP  <= 7'd0;
      end else begin
        case (state)
          IDLE, DONE, FAIL: begin
            if (TRAIN_START && PLL_LOCK) begin
              state                     <= CLEAR;
              EYE_MONITOR_LANE_WIDTH    <= LANE_WIDTH_CFG;
              EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b1;
              PHASE_DIR                 <= 1'b1;
              BUSY                      <= 1'b1;
              TRAIN_DONE                <= 1'b0;
              TRAIN_FAIL                <= 1'b0;
              BEST_STEP                 <= 7'd0;
              pos                       <= 7'd0;
              run_len                   <= 7'd0;
              run_start                 <= 7'd0;
              best_len                  <= 7'd0;
              best_start                <= 7'd0;
              target                    <= 7'd0;
`ifdef IOD_CLK_TRAIN_STEP_MAP_EN
              STEP_MAP                  <= '0;
`endif
            end
          end
          CLEAR: begin
            state <= SETTLE;
            cnt   <= '0;
            dirty <= 1'b0;
          end
          SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              state <= SAMPLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SAMPLE: begin
            dirty <= dirty | EYE_MONITOR_EARLY_0 | EYE_MONITOR_LATE_0;
            if (cnt == SAMPLE_LAST) state <= EVAL;
            else                    cnt   <= cnt + 1'b1;
          end
          EVAL: begin
            run_len    <= last_step ? 7'd0 : run_len_n;
            run_start  <= run_start_n;
            best_len   <= best_len_n;
            best_start <= best_start_n;
`ifdef IOD_CLK_TRAIN_STEP_MAP_EN
            if (dirty) STEP_MAP <= STEP_MAP | (MAX_STEPS'(1) << pos);
`endif
            if (!last_step) begin
              state <= STEP;
            end else if (best_len_n == 7'd0) begin
              state      <= FAIL;
              BUSY       <= 1'b0;
              TRAIN_FAIL <= 1'b1;
              BEST_STEP  <= 7'd0;
            end else begin
              state     <= CENTER;
              target    <= target_n;
              PHASE_DIR <= 1'b0;
            end
          end
          STEP: begin
            PHASE_MOVE                <= 1'b1;
            EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b1;
            pos                       <= pos + 7'd1;
            state                     <= CLEAR;
          end
          CENTER: begin
            if (pos == target) begin
              state      <= DONE;
              BUSY       <= 1'b0;
              TRAIN_DONE <= 1'b1;
              BEST_STEP  <= target;
            end else begin
              PHASE_MOVE <= 1'b1;
              pos        <= pos - 7'd1;
              cnt        <= '0;
              state      <= CSETTLE;
            end
          end
          CSETTLE: begin
            if (cnt == SETTLE_LAST) state <= CENTER;
            else                    cnt   <= cnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
